// File: rtl/ibex_pkg.sv
// Shared types and constants for the Ibex front-end blocks.
// Carries the instruction-buffer entry layout and its default depth.
// No logic lives here; modules import it with import ibex_pkg::*.

package ibex_pkg;

    // Default number of entries in the fetch-to-decode instruction buffer.
    localparam int unsigned IBUF_DEPTH_DEFAULT = 2;

    // Width of a fetched (already expanded) instruction word and of a PC.
    localparam int unsigned IBUF_XLEN = 32;

    // One buffered instruction. The packed layout is {err, illegal_c, addr, rdata},
    // 66 bits in total, with the error flag in the MSB.
    typedef struct packed {
        logic                 err;
        logic                 illegal_c;
        logic [IBUF_XLEN-1:0] addr;
        logic [IBUF_XLEN-1:0] rdata;
    } ibuf_entry_t;

    localparam int unsigned IBUF_ENTRY_W = $bits(ibuf_entry_t);

endpackage : ibex_pkg

// File: rtl/ibex_instr_buffer.sv
// Instruction buffer between fetch (post compressed expansion) and decode.
// Holds DEPTH entries of {err, illegal_c, addr, rdata}, presents the head to
// the decoder and raises instr_new_o in the first cycle an entry sits at the head.
//
// Latency: an entry pushed into an empty buffer is visible on out_* one cycle
// later (no bypass path).
// Backpressure: in_ready_o depends only on the fill count (and reset), never on
// id_ready_i, so there is no combinational path from decode back to fetch.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_i                 drop every entry (branch/jump redirect)
//   in_valid_i/in_ready_o   fetch handshake; in_rdata_i, in_addr_i,
//                           in_illegal_c_i, in_err_i carry the entry
//   out_valid_o/id_ready_i  decode handshake; out_rdata_o, out_addr_o,
//                           out_illegal_c_o, out_err_o show the head (0 when empty)
//   instr_new_o             first cycle the current head is presented
//   occupancy_o             number of valid entries

module ibex_instr_buffer
    import ibex_pkg::*;
#(
    parameter int unsigned DEPTH = IBUF_DEPTH_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,

    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [31:0]                in_rdata_i,
    input  logic [31:0]                in_addr_i,
    input  logic                       in_illegal_c_i,
    input  logic                       in_err_i,

    output logic                       out_valid_o,
    output logic [31:0]                out_rdata_o,
    output logic [31:0]                out_addr_o,
    output logic                       out_illegal_c_o,
    output logic                       out_err_o,
    output logic                       instr_new_o,
    input  logic                       id_ready_i,

    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_EMPTY = '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ibuf_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic              head_seen_q, head_seen_d;

    logic              push;
    logic              pop;
    ibuf_entry_t       wr_entry;
    ibuf_entry_t       head_entry;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // Ready is forced low during reset so fetch never sees an acceptance
    // that the reset is about to throw away.
    assign in_ready_o  = (count_q != CNT_FULL) & ~rst_i;
    assign out_valid_o = (count_q != CNT_EMPTY);

    // A flush cancels both handshakes in its cycle; the ready/valid outputs
    // still show their pre-flush values, so fetch must not treat a transfer
    // in the flush cycle as accepted.
    assign push = in_valid_i  & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & id_ready_i & ~flush_i;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    assign wr_entry.err       = in_err_i;
    assign wr_entry.illegal_c = in_illegal_c_i;
    assign wr_entry.addr      = in_addr_i;
    assign wr_entry.rdata     = in_rdata_i;

    // Entry contents carry no reset: they are only observable while the
    // count says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign head_entry = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Pointer / count / head-tracking next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        head_seen_d = head_seen_q;

        if (flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            head_seen_d = 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by plain overflow.
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            // The head has been "seen" once it survives a cycle without being
            // consumed; a pop hands the head slot to a fresh entry.
            if (pop) begin
                head_seen_d = 1'b0;
            end else if (out_valid_o) begin
                head_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_seen_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_seen_q <= head_seen_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Head fields are zeroed when empty so the decoder never sees stale data.
    assign out_rdata_o     = out_valid_o ? head_entry.rdata     : '0;
    assign out_addr_o      = out_valid_o ? head_entry.addr      : '0;
    assign out_illegal_c_o = out_valid_o ? head_entry.illegal_c : 1'b0;
    assign out_err_o       = out_valid_o ? head_entry.err       : 1'b0;

    assign instr_new_o     = out_valid_o & ~head_seen_q;
    assign occupancy_o     = count_q;

endmodule : ibex_instr_buffer

// File: tb/tb_ibex_instr_buffer.sv
// Self-checking bench for ibex_instr_buffer: directed scenarios plus a
// randomized run compared against a queue-based reference model.
// Inputs are driven 2 time units after each rising edge; outputs are read there.

module tb_ibex_instr_buffer;

    localparam int DEPTH = 2;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [31:0]      in_rdata_i = '0;
    logic [31:0]      in_addr_i = '0;
    logic             in_illegal_c_i = 1'b0;
    logic             in_err_i = 1'b0;
    logic             out_valid_o;
    logic [31:0]      out_rdata_o;
    logic [31:0]      out_addr_o;
    logic             out_illegal_c_o;
    logic             out_err_o;
    logic             instr_new_o;
    logic             id_ready_i = 1'b0;
    logic [OCC_W-1:0] occupancy_o;

    int tests_run = 0;
    int failures  = 0;

    // Reference model: queue of {err, illegal_c, addr, rdata}; head_age counts
    // the cycles the current head has already been presented.
    logic [65:0] mq[$];
    int          head_age = 0;

    ibex_instr_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_rdata_i      (in_rdata_i),
        .in_addr_i       (in_addr_i),
        .in_illegal_c_i  (in_illegal_c_i),
        .in_err_i        (in_err_i),
        .out_valid_o     (out_valid_o),
        .out_rdata_o     (out_rdata_o),
        .out_addr_o      (out_addr_o),
        .out_illegal_c_o (out_illegal_c_o),
        .out_err_o       (out_err_o),
        .instr_new_o     (instr_new_o),
        .id_ready_i      (id_ready_i),
        .occupancy_o     (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock and apply the buffer rules to the model.
    task automatic tick();
        bit m_rdy, m_vld, push, pop;
        @(posedge clk_i);
        m_rdy = (mq.size() != DEPTH) && !rst_i;
        m_vld = (mq.size() != 0);
        push  = in_valid_i && m_rdy && !flush_i;
        pop   = m_vld && id_ready_i && !flush_i;
        if (rst_i || flush_i) begin
            mq.delete();
            head_age = 0;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                head_age = 0;
            end else if (m_vld) begin
                head_age++;
            end
            if (push) mq.push_back({in_err_i, in_illegal_c_i, in_addr_i, in_rdata_i});
        end
        #2;
    endtask

    task automatic drive_in(input bit v, input logic [31:0] d, input logic [31:0] a,
                            input bit ill, input bit err);
        in_valid_i     = v;
        in_rdata_i     = d;
        in_addr_i      = a;
        in_illegal_c_i = ill;
        in_err_i       = err;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_in(1'b1, 32'hdead_beef, 32'h4, 1'b0, 1'b0);
            #1;
            tests_run++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL reset_in_ready cyc%0d: got %b want 0", i, in_ready_o); end
            tick();
        end
        tests_run++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
        drive_in(1'b0, '0, '0, 1'b0, 1'b0);
        rst_i = 1'b0;
        #1;
        tests_run++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready_o); end
        tests_run++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid_o); end
        tests_run++; if (instr_new_o !== 1'b0) begin failures++; $display("FAIL post_reset_instr_new: got %b want 0", instr_new_o); end
        tests_run++; if (occupancy_o !== OCC_W'(0)) begin failures++; $display("FAIL post_reset_occ: got %0d want 0", occupancy_o); end
        tests_run++; if (out_rdata_o !== 32'h0) begin failures++; $display("FAIL post_reset_rdata: got %h want 0", out_rdata_o); end
        tick();
    endtask

    task automatic test_single();
        id_ready_i = 1'b0;
        drive_in(1'b1, 32'h0000_0093, 32'h0000_0080, 1'b0, 1'b0);
        tick();
        drive_in(1'b0, '0, '0, 1'b0, 1'b0);
        tests_run++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", out_valid_o); end
        tests_run++; if (instr_new_o !== 1'b1) begin failures++; $display("FAIL single_new: got %b want 1", instr_new_o); end
        tests_run++; if (out_rdata_o !== 32'h0000_0093) begin failures++; $display("FAIL single_rdata: got %h want 00000093", out_rdata_o); end
        tests_run++; if (out_addr_o !== 32'h0000_0080) begin failures++; $display("FAIL single_addr: got %h want 00000080", out_addr_o); end
        tick();
        tests_run++; if (instr_new_o !== 1'b0) begin failures++; $display("FAIL single_new_2nd: got %b want 0", instr_new_o); end
        tests_run++; if (out_rdata_o !== 32'h0000_0093) begin failures++; $display("FAIL single_rdata_2nd: got %h want 00000093", out_rdata_o); end
        id_ready_i = 1'b1;
        tick();
        id_ready_i = 1'b0;
        tests_run++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL single_popped: got %b want 0", out_valid_o); end
    endtask

    task automatic test_fill_order();
        id_ready_i = 1'b0;
        drive_in(1'b1, 32'hAAAA_0001, 32'h0000_0200, 1'b0, 1'b0);
        tick();
        drive_in(1'b1, 32'hBBBB_0002, 32'h0000_0204, 1'b0, 1'b0);
        tick();
        drive_in(1'b1, 32'hCCCC_0003, 32'h0000_0208, 1'b0, 1'b0);
        #1;
        tests_run++; if (occupancy_o !== OCC_W'(2)) begin failures++; $display("FAIL fill_occ: got %0d want 2", occupancy_o); end
        tests_run++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL fill_ready: got %b want 0", in_ready_o); end
        tick();
        drive_in(1'b0, '0, '0, 1'b0, 1'b0);
        tests_run++; if (occupancy_o !== OCC_W'(2)) begin failures++; $display("FAIL fill_third_rejected: occ got %0d want 2", occupancy_o); end
        tests_run++; if (out_rdata_o !== 32'hAAAA_0001) begin failures++; $display("FAIL fill_head_A: got %h want AAAA0001", out_rdata_o); end
        id_ready_i = 1'b1;
        tick();
        tests_run++; if (out_rdata_o !== 32'hBBBB_0002) begin failures++; $display("FAIL fill_head_B: got %h want BBBB0002", out_rdata_o); end
        tests_run++; if (instr_new_o !== 1'b1) begin failures++; $display("FAIL fill_new_B: got %b want 1", instr_new_o); end
        tick();
        id_ready_i = 1'b0;
        tests_run++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL fill_drained: got %b want 0", out_valid_o); end
    endtask

    task automatic test_back_to_back();
        id_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_in(1'b1, 32'h1000_0000 + i, 32'h100 + 4 * i, 1'b0, 1'b0);
            tick();
            tests_run++; if (out_addr_o !== 32'(32'h100 + 4 * i)) begin failures++; $display("FAIL stream_addr %0d: got %h want %h", i, out_addr_o, 32'h100 + 4 * i); end
            tests_run++; if (occupancy_o !== OCC_W'(1)) begin failures++; $display("FAIL stream_occ %0d: got %0d want 1", i, occupancy_o); end
            tests_run++; if (instr_new_o !== 1'b1) begin failures++; $display("FAIL stream_new %0d: got %b want 1", i, instr_new_o); end
        end
        drive_in(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        id_ready_i = 1'b0;
        tests_run++; if (occupancy_o !== OCC_W'(0)) begin failures++; $display("FAIL stream_drain: got %0d want 0", occupancy_o); end
    endtask

    task automatic test_flush();
        id_ready_i = 1'b0;
        drive_in(1'b1, 32'h1111_0001, 32'h300, 1'b0, 1'b0);
        tick();
        drive_in(1'b1, 32'h1111_0002, 32'h304, 1'b0, 1'b0);
        tick();
        flush_i = 1'b1;
        id_ready_i = 1'b1;
        drive_in(1'b1, 32'h1111_0003, 32'h308, 1'b0, 1'b0);
        #1;
        tests_run++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL flush_cycle_valid: got %b want 1", out_valid_o); end
        tick();
        flush_i = 1'b0;
        id_ready_i = 1'b0;
        drive_in(1'b0, '0, '0, 1'b0, 1'b0);
        tests_run++; if (occupancy_o !== OCC_W'(0)) begin failures++; $display("FAIL flush_occ: got %0d want 0", occupancy_o); end
        tests_run++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b want 0", out_valid_o); end
        drive_in(1'b1, 32'h2222_0004, 32'h400, 1'b0, 1'b0);
        tick();
        drive_in(1'b0, '0, '0, 1'b0, 1'b0);
        tests_run++; if (out_addr_o !== 32'h400) begin failures++; $display("FAIL flush_next_head: got %h want 00000400", out_addr_o); end
        tests_run++; if (instr_new_o !== 1'b1) begin failures++; $display("FAIL flush_next_new: got %b want 1", instr_new_o); end
        id_ready_i = 1'b1;
        tick();
        id_ready_i = 1'b0;
    endtask

    task automatic test_flags();
        drive_in(1'b1, 32'h3333_0001, 32'h500, 1'b1, 1'b1);
        tick();
        drive_in(1'b1, 32'h3333_0002, 32'h504, 1'b0, 1'b0);
        tick();
        drive_in(1'b0, '0, '0, 1'b0, 1'b0);
        tests_run++; if (out_illegal_c_o !== 1'b1) begin failures++; $display("FAIL flags_ill: got %b want 1", out_illegal_c_o); end
        tests_run++; if (out_err_o !== 1'b1) begin failures++; $display("FAIL flags_err: got %b want 1", out_err_o); end
        id_ready_i = 1'b1;
        tick();
        id_ready_i = 1'b0;
        tests_run++; if (out_illegal_c_o !== 1'b0) begin failures++; $display("FAIL flags_ill_clean: got %b want 0", out_illegal_c_o); end
        tests_run++; if (out_err_o !== 1'b0) begin failures++; $display("FAIL flags_err_clean: got %b want 0", out_err_o); end
        tests_run++; if (out_addr_o !== 32'h504) begin failures++; $display("FAIL flags_addr: got %h want 00000504", out_addr_o); end
        id_ready_i = 1'b1;
        tick();
        id_ready_i = 1'b0;
    endtask

    task automatic test_random();
        logic [65:0] exp_head;
        bit          exp_vld, exp_rdy, exp_new;
        for (int c = 0; c < 600; c++) begin
            rst_i      = ($urandom_range(49) == 0);
            flush_i    = ($urandom_range(15) == 0);
            id_ready_i = $urandom_range(1);
            drive_in($urandom_range(1), $urandom, $urandom, $urandom_range(1), $urandom_range(1));
            #1;
            exp_vld  = (mq.size() != 0);
            exp_rdy  = (mq.size() != DEPTH) && !rst_i;
            exp_new  = exp_vld && (head_age == 0);
            exp_head = exp_vld ? mq[0] : 66'h0;
            tests_run++; if (in_ready_o !== exp_rdy) begin failures++; $display("FAIL rnd_ready c%0d: got %b want %b", c, in_ready_o, exp_rdy); end
            tests_run++; if (out_valid_o !== exp_vld) begin failures++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid_o, exp_vld); end
            tests_run++; if (instr_new_o !== exp_new) begin failures++; $display("FAIL rnd_new c%0d: got %b want %b", c, instr_new_o, exp_new); end
            tests_run++; if (occupancy_o !== OCC_W'(mq.size())) begin failures++; $display("FAIL rnd_occ c%0d: got %0d want %0d", c, occupancy_o, mq.size()); end
            tests_run++; if ({out_err_o, out_illegal_c_o, out_addr_o, out_rdata_o} !== exp_head) begin failures++; $display("FAIL rnd_head c%0d: got %h want %h", c, {out_err_o, out_illegal_c_o, out_addr_o, out_rdata_o}, exp_head); end
            tick();
        end
        rst_i = 1'b0;
        flush_i = 1'b0;
        id_ready_i = 1'b0;
        drive_in(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_order();
        test_back_to_back();
        test_flush();
        test_flags();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule : tb_ibex_instr_buffer
